// File: rtl/pong_engine.sv
// pong_engine
// Game core for the VGA paddle/ball demo. Holds the paddle and ball state and
// moves the ball with a signed per-axis velocity. Wall and paddle bounces are
// resolved once per frame. Score and lives are tracked through a
// SERVE / PLAY / OVER state machine. Ball, paddle and border are rendered into
// registered 4-bit RGB.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high; has priority over frame_tick
//   frame_tick   one-cycle pulse per frame; game state changes only here
//   btn_left     paddle left (already synchronised)
//   btn_right    paddle right (already synchronised)
//   display_en   visible-area flag from vga_sync
//   x_pos/y_pos  current pixel coordinate from vga_sync
//   red/green/blue  registered pixel colour, one clock after x_pos/y_pos
//   score        paddle hits, saturating at 255
//   lives        remaining lives
//   game_over    high while in OVER
module pong_engine #(
    parameter int H_ACTIVE     = 800,
    parameter int V_ACTIVE     = 600,
    parameter int COORD_W      = 11,
    parameter int BORDER       = 20,
    parameter int PADDLE_W     = 150,
    parameter int PADDLE_H     = 20,
    parameter int PADDLE_Y     = 560,
    parameter int BALL_SIZE    = 20,
    parameter int BALL_SPEED   = 4,
    parameter int PADDLE_STEP  = 8,
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               display_en,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic [7:0]         score,
    output logic [2:0]         lives,
    output logic               game_over
);

    localparam int CW1   = COORD_W + 1;
    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;

    // Signed physics constants: one extra bit so no step can wrap.
    localparam logic signed [COORD_W:0] C_ZERO    = CW1'(0);
    localparam logic signed [COORD_W:0] C_BORDER  = CW1'(BORDER);
    localparam logic signed [COORD_W:0] C_XR      = CW1'(H_ACTIVE - BORDER);
    localparam logic signed [COORD_W:0] C_BALL    = CW1'(BALL_SIZE);
    localparam logic signed [COORD_W:0] C_BX_MAX  = CW1'(H_ACTIVE - BORDER - BALL_SIZE);
    localparam logic signed [COORD_W:0] C_PAD_Y   = CW1'(PADDLE_Y);
    localparam logic signed [COORD_W:0] C_PAD_BOT = CW1'(PADDLE_Y + PADDLE_H);
    localparam logic signed [COORD_W:0] C_BY_HIT  = CW1'(PADDLE_Y - BALL_SIZE);
    localparam logic signed [COORD_W:0] C_PAD_W   = CW1'(PADDLE_W);
    localparam logic signed [COORD_W:0] C_PSTEP   = CW1'(PADDLE_STEP);
    localparam logic signed [COORD_W:0] C_PAD_MIN = CW1'(BORDER);
    localparam logic signed [COORD_W:0] C_PAD_MAX = CW1'(H_ACTIVE - BORDER - PADDLE_W);
    localparam logic signed [COORD_W:0] C_SPD_P   = CW1'(BALL_SPEED);
    localparam logic signed [COORD_W:0] C_SPD_N   = CW1'(-BALL_SPEED);

    // Unsigned constants for reset/recentre values and rendering.
    localparam logic [COORD_W-1:0] U_PAD_X0  = COORD_W'((H_ACTIVE - PADDLE_W) / 2);
    localparam logic [COORD_W-1:0] U_BALL_X0 = COORD_W'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] U_BALL_Y0 = COORD_W'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [COORD_W:0]   U_BALL    = CW1'(BALL_SIZE);
    localparam logic [COORD_W:0]   U_PAD_W   = CW1'(PADDLE_W);
    localparam logic [COORD_W:0]   U_PAD_Y   = CW1'(PADDLE_Y);
    localparam logic [COORD_W:0]   U_PAD_BOT = CW1'(PADDLE_Y + PADDLE_H);
    localparam logic [COORD_W:0]   U_BORDER  = CW1'(BORDER);
    localparam logic [COORD_W:0]   U_XR      = CW1'(H_ACTIVE - BORDER);
    localparam logic [CNT_W-1:0]   U_CNT_END = CNT_W'(SERVE_FRAMES - 1);

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_serve_cnt;
    logic [COORD_W-1:0]       r_paddle_x;
    logic [COORD_W-1:0]       r_ball_x;
    logic [COORD_W-1:0]       r_ball_y;
    logic signed [COORD_W:0]  r_vx;
    logic signed [COORD_W:0]  r_vy;
    logic [7:0]               r_score;
    logic [2:0]               r_lives;
    logic                     r_game_over;
    logic [11:0]              r_rgb;

    logic signed [COORD_W:0]  w_px;
    logic signed [COORD_W:0]  w_bx;
    logic signed [COORD_W:0]  w_by;
    logic signed [COORD_W:0]  w_nx;
    logic signed [COORD_W:0]  w_ny;
    logic signed [COORD_W:0]  w_pad_move;
    logic signed [COORD_W:0]  w_pad_next;
    logic signed [COORD_W:0]  w_bx_next;
    logic signed [COORD_W:0]  w_vx_next;
    logic signed [COORD_W:0]  w_by_next;
    logic signed [COORD_W:0]  w_vy_next;
    logic                     w_hit;
    logic                     w_miss;
    logic [COORD_W:0]         w_xu;
    logic [COORD_W:0]         w_yu;
    logic                     w_in_ball;
    logic                     w_in_paddle;
    logic                     w_in_border;

    assign w_px = $signed({1'b0, r_paddle_x});
    assign w_bx = $signed({1'b0, r_ball_x});
    assign w_by = $signed({1'b0, r_ball_y});
    assign w_nx = w_bx + r_vx;
    assign w_ny = w_by + r_vy;

    // Paddle step from the buttons, clamped inside the side borders.
    always_comb begin
        w_pad_move = w_px;
        w_pad_next = w_px;
        if (btn_left && !btn_right) begin
            w_pad_move = w_px - C_PSTEP;
        end else if (btn_right && !btn_left) begin
            w_pad_move = w_px + C_PSTEP;
        end else begin
            w_pad_move = w_px;
        end
        if (w_pad_move < C_PAD_MIN) begin
            w_pad_next = C_PAD_MIN;
        end else if (w_pad_move > C_PAD_MAX) begin
            w_pad_next = C_PAD_MAX;
        end else begin
            w_pad_next = w_pad_move;
        end
    end

    // Ball motion for PLAY: X and Y resolve independently so corners reflect both.
    always_comb begin
        w_bx_next = w_nx;
        w_vx_next = r_vx;
        w_by_next = w_ny;
        w_vy_next = r_vy;
        if (w_nx < C_BORDER) begin
            w_bx_next = C_BORDER;
            w_vx_next = C_SPD_P;
        end else if (w_nx + C_BALL > C_XR) begin
            w_bx_next = C_BX_MAX;
            w_vx_next = C_SPD_N;
        end else begin
            w_bx_next = w_nx;
            w_vx_next = r_vx;
        end
        // Hit test uses the paddle position from before this frame's move.
        w_hit  = (r_vy > C_ZERO) && (w_by + C_BALL <= C_PAD_Y) &&
                 (w_ny + C_BALL >= C_PAD_Y) && (w_nx + C_BALL > w_px) &&
                 (w_nx < w_px + C_PAD_W);
        w_miss = (w_ny + C_BALL > C_PAD_BOT);
        if (w_ny < C_BORDER) begin
            w_by_next = C_BORDER;
            w_vy_next = C_SPD_P;
        end else if (w_hit) begin
            w_by_next = C_BY_HIT;
            w_vy_next = C_SPD_N;
        end else begin
            w_by_next = w_ny;
            w_vy_next = r_vy;
        end
    end

    // Game state machine, advanced once per frame_tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SERVE;
            r_serve_cnt <= '0;
            r_paddle_x  <= U_PAD_X0;
            r_ball_x    <= U_BALL_X0;
            r_ball_y    <= U_BALL_Y0;
            r_vx        <= C_SPD_P;
            r_vy        <= C_SPD_N;
            r_score     <= 8'd0;
            r_lives     <= 3'(LIVES);
            r_game_over <= 1'b0;
        end else if (frame_tick) begin
            case (r_state)
                ST_SERVE: begin
                    r_paddle_x <= w_pad_next[COORD_W-1:0];
                    r_ball_x   <= U_BALL_X0;
                    r_ball_y   <= U_BALL_Y0;
                    if (r_serve_cnt == U_CNT_END) begin
                        r_state     <= ST_PLAY;
                        r_serve_cnt <= '0;
                        r_vx        <= C_SPD_P;
                        r_vy        <= C_SPD_N;
                    end else begin
                        r_serve_cnt <= r_serve_cnt + CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    r_paddle_x <= w_pad_next[COORD_W-1:0];
                    if (w_miss && !w_hit) begin
                        r_lives <= r_lives - 3'd1;
                        if (r_lives == 3'd1) begin
                            // Ball freezes where it was when the last life is lost.
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state     <= ST_SERVE;
                            r_serve_cnt <= '0;
                            r_ball_x    <= U_BALL_X0;
                            r_ball_y    <= U_BALL_Y0;
                        end
                    end else begin
                        r_ball_x <= w_bx_next[COORD_W-1:0];
                        r_vx     <= w_vx_next;
                        r_ball_y <= w_by_next[COORD_W-1:0];
                        r_vy     <= w_vy_next;
                        if (w_hit && (r_score != 8'hFF)) begin
                            r_score <= r_score + 8'd1;
                        end
                    end
                end
                ST_OVER: begin
                    if (btn_left && btn_right) begin
                        r_state     <= ST_SERVE;
                        r_serve_cnt <= '0;
                        r_lives     <= 3'(LIVES);
                        r_score     <= 8'd0;
                        r_ball_x    <= U_BALL_X0;
                        r_ball_y    <= U_BALL_Y0;
                        r_vx        <= C_SPD_P;
                        r_vy        <= C_SPD_N;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_SERVE;
                    r_serve_cnt <= '0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign w_xu = {1'b0, x_pos};
    assign w_yu = {1'b0, y_pos};

    // Object hit-tests for the current pixel, half-open unsigned ranges.
    always_comb begin
        w_in_ball   = (w_xu >= {1'b0, r_ball_x}) && (w_xu < {1'b0, r_ball_x} + U_BALL) &&
                      (w_yu >= {1'b0, r_ball_y}) && (w_yu < {1'b0, r_ball_y} + U_BALL);
        w_in_paddle = (w_xu >= {1'b0, r_paddle_x}) && (w_xu < {1'b0, r_paddle_x} + U_PAD_W) &&
                      (w_yu >= U_PAD_Y) && (w_yu < U_PAD_BOT);
        w_in_border = (w_xu < U_BORDER) || (w_xu >= U_XR) ||
                      (w_yu < U_BORDER) || (w_yu >= U_PAD_BOT);
    end

    // Registered pixel colour: ball over paddle over border over background.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb <= 12'h000;
        end else if (!display_en) begin
            r_rgb <= 12'h000;
        end else if (w_in_ball) begin
            r_rgb <= 12'h00F;
        end else if (w_in_paddle) begin
            r_rgb <= 12'h0F0;
        end else if (w_in_border) begin
            r_rgb <= 12'h000;
        end else if (r_state == ST_OVER) begin
            r_rgb <= 12'hF00;
        end else begin
            r_rgb <= 12'hFFF;
        end
    end

    assign red       = r_rgb[11:8];
    assign green     = r_rgb[7:4];
    assign blue      = r_rgb[3:0];
    assign score     = r_score;
    assign lives     = r_lives;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine
// Directed bench for pong_engine with default parameters. The ball follows a
// deterministic trajectory from the serve; expected positions along it are
// worked out by hand (launch (394,286), top wall, right wall, paddle hit,
// miss) and compared at fixed frame counts.
module tb_pong_engine;

    localparam int ST_SERVE = 0;
    localparam int ST_PLAY  = 1;
    localparam int ST_OVER  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        display_en = 1'b0;
    logic [10:0] x_pos = 11'd0;
    logic [10:0] y_pos = 11'd0;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [7:0]  score;
    logic [2:0]  lives;
    logic        game_over;

    int n_checks = 0;
    int n_fails  = 0;

    pong_engine dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .display_en (display_en),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .score      (score),
        .lives      (lives),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One frame_tick pulse per frame, returning on a falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_ball(input string tag, input int bx, input int by);
        check_eq({tag, ".ball_x"}, int'(dut.r_ball_x), bx);
        check_eq({tag, ".ball_y"}, int'(dut.r_ball_y), by);
    endtask

    // Drive a pixel and check the colour one clock later.
    task automatic pix(input string tag, input int x, input int y, input bit en, input int exp_rgb);
        @(negedge clk);
        x_pos      = 11'(x);
        y_pos      = 11'(y);
        display_en = en;
        @(negedge clk);
        check_eq(tag, int'({red, green, blue}), exp_rgb);
    endtask

    initial begin
        // Reset values, checked while reset is still held.
        display_en = 1'b1;
        x_pos = 11'd400;
        y_pos = 11'd100;
        repeat (3) @(negedge clk);
        check_eq("rst.rgb", int'({red, green, blue}), 12'h000);
        check_eq("rst.paddle", int'(dut.r_paddle_x), 325);
        check_ball("rst", 390, 290);
        check_eq("rst.vx", int'(dut.r_vx), 4);
        check_eq("rst.vy", int'(dut.r_vy), -4);
        check_eq("rst.score", int'(score), 0);
        check_eq("rst.lives", int'(lives), 3);
        check_eq("rst.game_over", int'(game_over), 0);
        check_eq("rst.state", int'(dut.r_state), ST_SERVE);
        reset = 1'b0;

        // Rendering in SERVE: ball at (390,290), paddle at 325.
        pix("pix.bg", 400, 100, 1'b1, 12'hFFF);
        @(negedge clk);
        x_pos = 11'd390;
        y_pos = 11'd290;
        #2;
        check_eq("pix.latency_hold", int'({red, green, blue}), 12'hFFF);
        @(negedge clk);
        check_eq("pix.ball_tl", int'({red, green, blue}), 12'h00F);
        pix("pix.ball_br", 409, 309, 1'b1, 12'h00F);
        pix("pix.ball_right_edge", 410, 290, 1'b1, 12'hFFF);
        pix("pix.ball_left_edge", 389, 290, 1'b1, 12'hFFF);
        pix("pix.paddle_tl", 325, 560, 1'b1, 12'h0F0);
        pix("pix.paddle_br", 474, 579, 1'b1, 12'h0F0);
        pix("pix.paddle_right_edge", 475, 565, 1'b1, 12'hFFF);
        pix("pix.border_left", 10, 100, 1'b1, 12'h000);
        pix("pix.border_bottom", 400, 580, 1'b1, 12'h000);
        pix("pix.inside_right", 779, 100, 1'b1, 12'hFFF);
        pix("pix.border_right", 780, 100, 1'b1, 12'h000);
        pix("pix.blank", 390, 290, 1'b0, 12'h000);

        // Serve: ball held at centre, launch after SERVE_FRAMES ticks.
        tick(59);
        check_eq("serve59.state", int'(dut.r_state), ST_SERVE);
        check_ball("serve59", 390, 290);
        tick(1);
        check_eq("serve60.state", int'(dut.r_state), ST_PLAY);
        check_ball("serve60", 390, 290);
        repeat (5) @(negedge clk);
        check_ball("no_tick_hold", 390, 290);
        tick(1);
        check_ball("launch", 394, 286);

        // Up-right to the top wall.
        tick(66);
        check_ball("pre_top", 658, 22);
        tick(1);
        check_ball("top_bounce", 662, 20);
        check_eq("top_bounce.vy", int'(dut.r_vy), 4);
        // Down-right to the right wall.
        tick(24);
        check_ball("pre_right", 758, 116);
        tick(1);
        check_ball("right_bounce", 760, 120);
        check_eq("right_bounce.vx", int'(dut.r_vx), -4);
        // Down-left onto the paddle at 325.
        tick(104);
        check_ball("pre_hit", 344, 536);
        check_eq("pre_hit.score", int'(score), 0);
        tick(1);
        check_ball("hit", 340, 540);
        check_eq("hit.vy", int'(dut.r_vy), -4);
        check_eq("hit.score", int'(score), 1);
        // Left wall, top wall, then down-right past the paddle.
        tick(266);
        check_ball("pre_miss", 760, 560);
        check_eq("pre_miss.lives", int'(lives), 3);
        tick(1);
        check_eq("miss1.lives", int'(lives), 2);
        check_eq("miss1.state", int'(dut.r_state), ST_SERVE);
        check_ball("miss1", 390, 290);
        check_eq("miss1.score", int'(score), 1);

        // Paddle parked at the right limit: next two serves miss.
        btn_right = 1'b1;
        tick(263);
        check_eq("serve2.lives", int'(lives), 2);
        check_eq("serve2.paddle", int'(dut.r_paddle_x), 630);
        tick(1);
        check_eq("miss2.lives", int'(lives), 1);
        check_eq("miss2.state", int'(dut.r_state), ST_SERVE);
        tick(263);
        check_eq("serve3.game_over", int'(game_over), 0);
        tick(1);
        check_eq("miss3.lives", int'(lives), 0);
        check_eq("miss3.game_over", int'(game_over), 1);
        check_eq("miss3.state", int'(dut.r_state), ST_OVER);
        btn_right = 1'b0;

        // Game over: red background, frozen paddle, restart on both buttons.
        pix("over.bg", 400, 100, 1'b1, 12'hF00);
        pix("over.border", 5, 100, 1'b1, 12'h000);
        btn_left = 1'b1;
        tick(1);
        check_eq("over.left_only", int'(game_over), 1);
        check_eq("over.paddle_frozen", int'(dut.r_paddle_x), 630);
        btn_right = 1'b1;
        tick(1);
        btn_left = 1'b0;
        btn_right = 1'b0;
        check_eq("restart.lives", int'(lives), 3);
        check_eq("restart.score", int'(score), 0);
        check_eq("restart.game_over", int'(game_over), 0);
        check_eq("restart.state", int'(dut.r_state), ST_SERVE);
        check_ball("restart", 390, 290);
        tick(61);
        check_ball("relaunch", 394, 286);

        // Reset on a frame_tick mid-PLAY wins over the tick.
        @(negedge clk);
        reset = 1'b1;
        frame_tick = 1'b1;
        btn_right = 1'b1;
        @(negedge clk);
        check_eq("midrst.paddle", int'(dut.r_paddle_x), 325);
        check_ball("midrst", 390, 290);
        check_eq("midrst.state", int'(dut.r_state), ST_SERVE);
        check_eq("midrst.vy", int'(dut.r_vy), -4);
        check_eq("midrst.rgb", int'({red, green, blue}), 12'h000);
        reset = 1'b0;
        frame_tick = 1'b0;
        btn_right = 1'b0;

        // Paddle left from 325, clamping at 20.
        btn_left = 1'b1;
        tick(1);
        check_eq("pad.l1", int'(dut.r_paddle_x), 317);
        tick(1);
        check_eq("pad.l2", int'(dut.r_paddle_x), 309);
        tick(36);
        check_eq("pad.l38", int'(dut.r_paddle_x), 21);
        tick(1);
        check_eq("pad.clamp", int'(dut.r_paddle_x), 20);
        tick(11);
        check_eq("pad.l50", int'(dut.r_paddle_x), 20);
        btn_right = 1'b1;
        tick(3);
        check_eq("pad.both", int'(dut.r_paddle_x), 20);
        btn_left = 1'b0;
        tick(1);
        check_eq("pad.right", int'(dut.r_paddle_x), 28);
        btn_right = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pong_engine.md
Name: pong_engine

Overview:
Parametrised game core for the VGA paddle/ball demo. Holds paddle and ball state, moves the ball with signed per-axis velocity, and resolves wall and paddle bounces once per frame. Tracks score and lives through a serve/play/miss/game-over state machine. Renders ball, paddle and border into registered 4-bit RGB, driven by the pixel coordinates from vga_sync.

Parameters:
H_ACTIVE, 800, visible width in pixels
V_ACTIVE, 600, visible height in pixels
COORD_W, 11, width of all coordinate signals
BORDER, 20, border thickness on the left, right and top edges
PADDLE_W, 150, paddle width
PADDLE_H, 20, paddle height
PADDLE_Y, 560, paddle top row
BALL_SIZE, 20, ball edge length (square)
BALL_SPEED, 4, ball step per frame, each axis
PADDLE_STEP, 8, paddle step per frame
LIVES, 3, lives at game start (1..7)
SERVE_FRAMES, 60, frames the ball waits at centre before launch

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (issued during vertical blank)
btn_left  in  1  move paddle left, active-high, already synchronised
btn_right  in  1  move paddle right, active-high, already synchronised
display_en  in  1  visible-area flag from vga_sync
x_pos  in  COORD_W  current pixel column
y_pos  in  COORD_W  current pixel row
red  out  4  pixel red
green  out  4  pixel green
blue  out  4  pixel blue
score  out  8  paddle hits, saturates at 255
lives  out  3  remaining lives
game_over  out  1  high in state OVER

Behaviour:
- Clock and reset: reset, synchronous, active-high; clock clk. Reset has priority over frame_tick.
- Reset values:
  - state = SERVE, serve counter = 0
  - paddle_x = (H_ACTIVE-PADDLE_W)/2
  - ball_x = (H_ACTIVE-BALL_SIZE)/2, ball_y = (V_ACTIVE-BALL_SIZE)/2
  - vx = +BALL_SPEED, vy = -BALL_SPEED
  - score = 0, lives = LIVES, game_over = 0, RGB = 0
- State updates happen only on cycles where frame_tick = 1. All other cycles hold state.
- Paddle (states SERVE and PLAY):
  - btn_left alone: paddle_x -= PADDLE_STEP.
  - btn_right alone: paddle_x += PADDLE_STEP.
  - Both buttons or neither: hold.
  - Clamp to [BORDER, H_ACTIVE-BORDER-PADDLE_W]. Compute in COORD_W+1 signed so no wrap occurs.
- SERVE:
  - Ball held at centre.
  - Counter increments per frame. At SERVE_FRAMES-1 the state goes to PLAY, counter clears, vx = +BALL_SPEED, vy = -BALL_SPEED.
- PLAY, per frame, with nx = ball_x+vx and ny = ball_y+vy:
  - Left wall: nx < BORDER -> ball_x = BORDER, vx = +BALL_SPEED.
  - Right wall: nx+BALL_SIZE > H_ACTIVE-BORDER -> ball_x = H_ACTIVE-BORDER-BALL_SIZE, vx = -BALL_SPEED.
  - Otherwise ball_x = nx.
  - Top wall: ny < BORDER -> ball_y = BORDER, vy = +BALL_SPEED.
  - Paddle hit: vy > 0, ball_y+BALL_SIZE <= PADDLE_Y, ny+BALL_SIZE >= PADDLE_Y, and horizontal overlap (nx+BALL_SIZE > paddle_x and nx < paddle_x+PADDLE_W). Result: ball_y = PADDLE_Y-BALL_SIZE, vy = -BALL_SPEED, score += 1 (saturating).
  - Miss: ny+BALL_SIZE > PADDLE_Y+PADDLE_H. Result: lives -= 1; if the new lives = 0, go to OVER, else go to SERVE with ball recentred and counter = 0.
  - Otherwise ball_y = ny.
  - X and Y resolve independently in the same frame, so a corner hit reflects both axes.
  - The paddle uses its pre-update paddle_x for the hit test.
- OVER:
  - game_over = 1, ball and paddle frozen.
  - btn_left & btn_right both high on a frame_tick -> lives = LIVES, score = 0, ball recentred, state = SERVE.
- Render, 1-cycle registered latency from x_pos/y_pos/display_en to RGB:
  - display_en = 0 -> black.
  - Otherwise, by priority:
    - Ball (x in [ball_x, ball_x+BALL_SIZE), y likewise) -> 0/0/F.
    - Paddle (x in [paddle_x, paddle_x+PADDLE_W), y in [PADDLE_Y, PADDLE_Y+PADDLE_H)) -> 0/F/0.
    - Border (x < BORDER, or x >= H_ACTIVE-BORDER, or y < BORDER, or y >= PADDLE_Y+PADDLE_H) -> 0/0/0.
    - Background -> F/F/F.
  - In OVER, the background is F/0/0.
- All range comparisons are half-open and unsigned, zero-extended to COORD_W+1.

Test Plan:
- Reset, then SERVE_FRAMES ticks -> ball at (390,290) until launch; after 1 more tick ball = (394,286), state PLAY.
- Hold btn_left for 50 ticks from paddle_x = 325 -> paddle_x steps 317, 309, … and clamps at 20; both buttons held -> paddle_x unchanged.
- Ball at x = 762, vx = +4 (right wall 780) -> ball_x = 760, vx = -4; same frame at y = 22 with vy = -4 -> ball_y = 20, vy = +4.
- Ball at y = 538, vy = +4, paddle_x = 300, ball_x = 350 -> ball_y = 540, vy = -4, score 0→1; repeat with ball_x = 600 -> miss, lives 3→2, state SERVE.
- Three consecutive misses -> game_over = 1, background red; both buttons on a tick -> lives = 3, score = 0, SERVE.
- Pixel (x = ball_x, y = ball_y) with display_en = 1 -> RGB 0/0/F exactly one clk later; display_en = 0 -> 0/0/0; reset asserted mid-PLAY on a frame_tick -> all reset values next cycle.
